// File: rtl/code_lock_pkg.sv
// Shared types and constants for the RGB code-lock controller.
package code_lock_pkg;

  localparam int CODE_LEN = 4;

  typedef logic [2:0] symbol_t;
  typedef symbol_t [CODE_LEN-1:0] code_t;

  localparam symbol_t SYM_RED   = 3'b100;
  localparam symbol_t SYM_GREEN = 3'b010;
  localparam symbol_t SYM_BLUE  = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTER    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_PROGRAM  = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  // Width needed to hold the larger of the two hold/lockout periods.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// User-side signals of the code lock: request/symbol inputs and status outputs.
interface code_lock_if;
  import code_lock_pkg::*;

  // Level-sampled inputs: Start/Prog/symbols are taken on every rising edge
  // in the states that use them; there is no valid/ready handshake.
  logic       Start;
  logic       Red;
  logic       Green;
  logic       Blue;
  logic       Prog;
  logic       U;
  logic       Locked;
  logic       Busy;
  logic       Fail;
  logic [1:0] FailCnt;
  state_t     dbg_state;

  modport master (
    output Start, Red, Green, Blue, Prog,
    input  U, Locked, Busy, Fail, FailCnt, dbg_state
  );

  modport slave (
    input  Start, Red, Green, Blue, Prog,
    output U, Locked, Busy, Fail, FailCnt, dbg_state
  );
endinterface

// File: rtl/code_timer.sv
// Loadable down-counter with enable and zero flag, shared by unlock hold and lockout.
module code_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/code_lock_controller.sv
// Code-lock sequencer: symbol entry, compare, fail counting, lockout, unlock hold, reprogramming.
module code_lock_controller
  import code_lock_pkg::*;
#(
  parameter int    MAX_FAIL       = 3,
  parameter int    LOCKOUT_CYCLES = 1000,
  parameter int    UNLOCK_CYCLES  = 50,
  parameter code_t DEFAULT_CODE   = 12'b110_001_010_100
) (
  input  logic     Clk,
  input  logic     Rst,
  code_lock_if.slave bus
);

  localparam int TMR_W = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES);
  localparam int IDX_W = $clog2(CODE_LEN);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  code_t            entry, entry_n;
  code_t            shadow, shadow_n;
  code_t            code_reg, code_n;
  logic [1:0]       fail_cnt, fail_cnt_n;
  logic             fail_q, fail_n;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_en;
  logic             tmr_zero;

  symbol_t          sym;
  logic [2:0]       cnt_inc;
  logic             last_sym;

  assign sym      = {bus.Red, bus.Green, bus.Blue};
  assign cnt_inc  = {1'b0, fail_cnt} + 3'd1;
  assign last_sym = (idx == IDX_W'(CODE_LEN - 1));

  code_timer #(.W(TMR_W)) u_timer (
    .clk        (Clk),
    .rst_n      (Rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      entry    <= '0;
      shadow   <= '0;
      code_reg <= DEFAULT_CODE;
      fail_cnt <= '0;
      fail_q   <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      entry    <= entry_n;
      shadow   <= shadow_n;
      code_reg <= code_n;
      fail_cnt <= fail_cnt_n;
      fail_q   <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    entry_n    = entry;
    shadow_n   = shadow;
    code_n     = code_reg;
    fail_cnt_n = fail_cnt;
    fail_n     = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_en     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          state_n = ST_ENTER;
          idx_n   = '0;
        end
      end

      ST_ENTER: begin
        entry_n[idx] = sym;
        idx_n        = idx + IDX_W'(1);
        if (last_sym) state_n = ST_CHECK;
      end

      ST_CHECK: begin
        if (entry == code_reg) begin
          state_n    = ST_UNLOCKED;
          fail_cnt_n = '0;
          tmr_load   = 1'b1;
          tmr_value  = TMR_W'(UNLOCK_CYCLES - 1);
        end else begin
          fail_n = 1'b1;
          // The count only reaches MAX_FAIL on the way into lockout.
          if (cnt_inc >= 3'(MAX_FAIL)) begin
            state_n    = ST_LOCKOUT;
            fail_cnt_n = 2'(MAX_FAIL);
            tmr_load   = 1'b1;
            tmr_value  = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_n    = ST_IDLE;
            fail_cnt_n = cnt_inc[1:0];
          end
        end
      end

      ST_UNLOCKED: begin
        if (bus.Prog) begin
          state_n = ST_PROGRAM;
          idx_n   = '0;
        end else if (bus.Start || tmr_zero) begin
          state_n = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_PROGRAM: begin
        shadow_n[idx] = sym;
        idx_n         = idx + IDX_W'(1);
        // Commit all symbols at once so an aborted entry leaves the code intact.
        if (last_sym) begin
          code_n  = shadow_n;
          state_n = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_zero) begin
          state_n    = ST_IDLE;
          fail_cnt_n = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.U         = (state == ST_UNLOCKED);
  assign bus.Locked    = (state == ST_LOCKOUT);
  assign bus.Busy      = (state == ST_ENTER) || (state == ST_CHECK) || (state == ST_PROGRAM);
  assign bus.Fail      = fail_q;
  assign bus.FailCnt   = fail_cnt;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_code_lock_controller.sv
// Randomized and directed bench for code_lock_controller against an abstract attempt/timer model.
module tb_code_lock_controller;
  import code_lock_pkg::*;

  localparam int          LOCK_C   = 8;
  localparam int          UNL_C    = 4;
  localparam int          MAXF     = 3;
  localparam logic [11:0] DEF_CODE = 12'b110_001_010_100;
  localparam logic [11:0] NEW_CODE = 12'b001_000_111_111;

  logic Clk;
  logic Rst;
  code_lock_if bus();

  code_lock_controller #(
    .MAX_FAIL       (MAXF),
    .LOCKOUT_CYCLES (LOCK_C),
    .UNLOCK_CYCLES  (UNL_C),
    .DEFAULT_CODE   (DEF_CODE)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An attempt is a queue of symbols; unlock and lockout are remaining-cycle counts.
  logic [11:0] m_code;
  logic [2:0]  att_q[$];
  logic [2:0]  prg_q[$];
  bit          m_entering, m_checking, m_programming, m_fail;
  int          m_unlock_left, m_lock_left, m_fails;

  function automatic logic [11:0] pack_syms(input logic [2:0] q[$]);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[3*i +: 3] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_code = DEF_CODE;
    att_q.delete();
    prg_q.delete();
    m_entering = 0; m_checking = 0; m_programming = 0; m_fail = 0;
    m_unlock_left = 0; m_lock_left = 0; m_fails = 0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    s = {bus.Red, bus.Green, bus.Blue};
    m_fail = 0;
    if (m_checking) begin
      m_checking = 0;
      if (pack_syms(att_q) == m_code) begin
        m_unlock_left = UNL_C;
        m_fails = 0;
      end else begin
        m_fail = 1;
        m_fails++;
        if (m_fails == MAXF) m_lock_left = LOCK_C;
      end
      att_q.delete();
    end else if (m_entering) begin
      att_q.push_back(s);
      if (att_q.size() == 4) begin
        m_entering = 0;
        m_checking = 1;
      end
    end else if (m_programming) begin
      prg_q.push_back(s);
      if (prg_q.size() == 4) begin
        m_code = pack_syms(prg_q);
        prg_q.delete();
        m_programming = 0;
      end
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_unlock_left > 0) begin
      if (bus.Prog) begin
        m_unlock_left = 0;
        m_programming = 1;
      end else if (bus.Start) begin
        m_unlock_left = 0;
      end else begin
        m_unlock_left--;
      end
    end else if (bus.Start) begin
      m_entering = 1;
    end
  endtask

  task automatic compare_all();
    chk("U",       32'(bus.U),       32'(m_unlock_left > 0));
    chk("Locked",  32'(bus.Locked),  32'(m_lock_left > 0));
    chk("Busy",    32'(bus.Busy),    32'(m_entering || m_checking || m_programming));
    chk("Fail",    32'(bus.Fail),    32'(m_fail));
    chk("FailCnt", 32'(bus.FailCnt), 32'(m_fails));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit st, input bit pg, input logic [2:0] s);
    bus.Start = st;
    bus.Prog  = pg;
    {bus.Red, bus.Green, bus.Blue} = s;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic attempt(input logic [11:0] c);
    set_in(1, 0, 3'b000);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, c[3*i +: 3]);
      cycle();
    end
    set_in(0, 0, 3'b000);
    cycle();
  endtask

  task automatic program_code(input logic [11:0] c);
    set_in(0, 1, 3'b000);
    cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, c[3*i +: 3]);
      cycle();
    end
    set_in(0, 0, 3'b000);
  endtask

  task automatic idle_cycles(input int n);
    set_in(0, 0, 3'b000);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] sym_q[$];
  int         n;

  initial begin
    set_in(0, 0, 3'b000);
    Rst = 1'b1;
    #2;
    do_reset();
    chk("rst_U", 32'(bus.U), 32'd0);
    chk("rst_FailCnt", 32'(bus.FailCnt), 32'd0);
    idle_cycles(2);

    // 1: correct entry, exact unlock window
    attempt({SYM_RED, SYM_BLUE, SYM_GREEN, SYM_RED} & 12'b0 | DEF_CODE);
    chk("t1_U", 32'(bus.U), 32'd1);
    n = 0;
    while (bus.U && n < 20) begin n++; cycle(); end
    chk("t1_unlock_len", 32'(n), 32'(UNL_C));
    chk("t1_FailCnt", 32'(bus.FailCnt), 32'd0);

    // 2: three wrong entries into lockout, Start ignored during lockout
    for (int k = 1; k <= 3; k++) begin
      attempt(12'h000);
      chk("t2_Fail", 32'(bus.Fail), 32'd1);
      chk("t2_FailCnt", 32'(bus.FailCnt), 32'(k));
    end
    n = 0;
    while (bus.Locked && n < 50) begin
      n++;
      set_in(n == 3, n == 4, 3'b000);
      cycle();
    end
    set_in(0, 0, 3'b000);
    chk("t2_lock_len", 32'(n), 32'(LOCK_C));
    chk("t2_FailCnt_after", 32'(bus.FailCnt), 32'd0);
    idle_cycles(2);

    // 3: reprogram, old code fails, new code unlocks
    attempt(DEF_CODE);
    program_code(NEW_CODE);
    idle_cycles(1);
    attempt(DEF_CODE);
    chk("t3_old_fail", 32'(bus.Fail), 32'd1);
    idle_cycles(1);
    attempt(NEW_CODE);
    chk("t3_new_U", 32'(bus.U), 32'd1);

    // 4: Prog beats Start; Start alone relocks on the next edge
    set_in(1, 1, 3'b000);
    cycle();
    chk("t4_prog_wins", 32'(bus.Busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, NEW_CODE[3*i +: 3]);
      cycle();
    end
    idle_cycles(1);
    attempt(NEW_CODE);
    idle_cycles(1);
    set_in(1, 0, 3'b000);
    cycle();
    chk("t4_relock", 32'(bus.U), 32'd0);
    idle_cycles(2);

    // 5: reset during third programming symbol
    attempt(NEW_CODE);
    set_in(0, 1, 3'b000);
    cycle();
    set_in(0, 0, 3'b111); cycle();
    set_in(0, 0, 3'b111); cycle();
    set_in(0, 0, 3'b000);
    do_reset();
    chk("t5_Busy", 32'(bus.Busy), 32'd0);
    idle_cycles(1);
    attempt(DEF_CODE);
    chk("t5_default_U", 32'(bus.U), 32'd1);
    idle_cycles(UNL_C + 1);
    attempt(NEW_CODE);
    chk("t5_partial_fail", 32'(bus.Fail), 32'd1);
    idle_cycles(1);

    // 6: failures cleared by success; two more do not lock
    attempt(12'h000);
    idle_cycles(1);
    chk("t6_FailCnt2", 32'(bus.FailCnt), 32'd2);
    attempt(DEF_CODE);
    chk("t6_cleared", 32'(bus.FailCnt), 32'd0);
    idle_cycles(UNL_C + 1);
    attempt(12'hfff);
    idle_cycles(1);
    attempt(12'hfff);
    idle_cycles(1);
    chk("t6_no_lock", 32'(bus.Locked), 32'd0);
    chk("t6_FailCnt", 32'(bus.FailCnt), 32'd2);
    attempt(DEF_CODE);
    idle_cycles(UNL_C + 1);

    // random phase
    for (int c = 0; c < 2000; c++) begin
      bit st, pg;
      logic [2:0] s;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        sym_q.delete();
        continue;
      end
      st = ($urandom_range(0, 5) == 0);
      pg = ($urandom_range(0, 7) == 0);
      if (st && sym_q.size() == 0) begin
        for (int i = 0; i < 4; i++)
          sym_q.push_back(($urandom_range(0, 1) == 0) ? m_code[3*i +: 3] : 3'($urandom_range(0, 7)));
      end
      s = (sym_q.size() > 0) ? sym_q.pop_front() : 3'($urandom_range(0, 7));
      set_in(st, pg, s);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/code_lock_controller.md
# code_lock_controller

Sequencing controller for the RGB code-lock datapath. It accepts a Start request and four consecutive Red/Green/Blue symbol samples, then compares them against a programmable 4-symbol code register. It counts failed attempts and enforces a timed lockout after repeated failures. It holds the unlock output for a bounded window, and allows the code to be re-programmed only while unlocked.

## Interface
- CODE_LEN, 4: symbols per attempt (fixed at 4; parameter exists for package sizing only)
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout
- LOCKOUT_CYCLES, 1000: lockout duration in Clk cycles
- UNLOCK_CYCLES, 50: unlock hold window in Clk cycles
- DEFAULT_CODE, 12'b110_001_010_100: code loaded at reset; symbol i occupies bits [3i+2:3i]
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  begin an attempt (sampled in IDLE and UNLOCKED only)
- Red, Green, Blue  input  1 each  symbol bits; symbol = {Red,Green,Blue}
- Prog  input  1  request code re-programming (honoured in UNLOCKED only)
- U  output  1  unlocked indicator
- Locked  output  1  lockout active
- Busy  output  1  attempt or programming in progress
- Fail  output  1  one-cycle pulse on a failed attempt
- FailCnt  output  2  consecutive failure count

## Operation
- States: IDLE, ENTER, CHECK, UNLOCKED, PROGRAM, LOCKOUT.
- IDLE + Start=1 -> ENTER; symbol index cleared.
- ENTER: capture {Red,Green,Blue} into the symbol slot at the current index on each of 4 edges; after the 4th capture -> CHECK. All 8 symbol values are legal, including 000. Start is ignored.
- CHECK (1 cycle): all 4 captured symbols equal to the code register -> UNLOCKED, FailCnt<=0, hold timer loaded with UNLOCK_CYCLES-1.
- CHECK, otherwise: Fail pulses and FailCnt increments. If the new FailCnt==MAX_FAIL -> LOCKOUT, timer loaded with LOCKOUT_CYCLES-1; else -> IDLE.
- UNLOCKED: U=1.
  - Prog=1 -> PROGRAM.
  - Else Start=1 -> IDLE (manual relock).
  - Else timer==0 -> IDLE; otherwise timer decrements.
  - Prog and Start together: Prog wins.
- PROGRAM: capture 4 symbols on 4 consecutive edges into a shadow register. After the 4th, the whole code register is written atomically -> IDLE. A partial entry never alters the code.
- LOCKOUT: Locked=1; Start and Prog ignored; timer decrements. When timer==0 -> IDLE and FailCnt<=0.
- FailCnt saturates at MAX_FAIL and only reaches it inside LOCKOUT.
- Timer width is $clog2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)); a single timer is shared by UNLOCKED and LOCKOUT.

## Timing
- Reset values:
  - State: IDLE
  - Outputs: U=0, Locked=0, Busy=0, Fail=0, FailCnt=0
  - Code register: DEFAULT_CODE
  - Timer: 0
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Start sampled at edge k: symbols are sampled at edges k+1..k+4 and CHECK executes at edge k+5. U (pass) or Fail (fail) is visible after edge k+5.
- U stays high for exactly UNLOCK_CYCLES cycles unless Prog or Start ends it early.
- Locked stays high for exactly LOCKOUT_CYCLES cycles.
- Busy=1 in ENTER, CHECK and PROGRAM.
- Reset asserted mid-attempt, mid-program or mid-lockout: immediate return to reset values, partially entered symbols discarded, code register reverts to DEFAULT_CODE.
- Symbol inputs are assumed synchronous to Clk. Debouncing and synchronisation are upstream.

## Structure
- Package code_lock_pkg:
  - state enum
  - symbol_t (3-bit) and code_t (CODE_LEN x symbol_t) typedefs
  - Symbol constants SYM_RED=3'b100, SYM_GREEN=3'b010, SYM_BLUE=3'b001
- Sub-module code_timer: loadable down-counter with load, enable and zero flag. It is instantiated once and shared by UNLOCKED and LOCKOUT.
- Remaining FSM, symbol index, capture and shadow registers, and comparator stay in the top module.

## Test plan
Bench parameters: LOCKOUT_CYCLES=8, UNLOCK_CYCLES=4, default code 12'b110_001_010_100.
1. Correct entry: Start, then symbols 100,010,001,110 -> U=1 after edge k+5 for exactly 4 cycles, then U=0, FailCnt=0.
2. Three wrong entries (000,000,000,000): Fail pulses each time and FailCnt goes 1,2,3. After the 3rd CHECK, Locked=1 for 8 cycles. A Start issued during lockout is ignored. Afterwards FailCnt=0.
3. Reprogram: unlock, assert Prog, enter 111,111,000,001 -> IDLE. The old code then fails and the new code unlocks.
4. Prog and Start on the same cycle in UNLOCKED -> PROGRAM entered. Start mid-unlock without Prog -> U drops on the next edge.
5. Rst pulled low during the 3rd symbol of programming -> all outputs at reset values. Default code still unlocks; the partial code does not.
6. Two failures, then a correct entry -> FailCnt returns to 0. Two further failures do not trigger lockout.
